axi4_lite_sys_bus_bridge: RTL

AXI4-Lite slave that converts PS general-purpose port accesses into single sys_bus transfers. It drives the master side of the system bus interconnect, which decodes and routes each transfer to a peripheral slave. The bridge handles one transaction at a time and arbitrates between reads and writes. A timeout counter turns a missing slave acknowledge into an AXI error response.

---
 rtl/axi4_lite_sys_bus_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_sys_bus_bridge.sv
// AXI4-Lite slave bridging single PS accesses onto the sys_bus master port.
// One transaction in flight; a timeout turns a silent slave into DECERR.
module axi4_lite_sys_bus_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [AW-1:0]     axi_awaddr_i,
    input  logic              axi_awvalid_i,
    output logic              axi_awready_o,
    input  logic [DW-1:0]     axi_wdata_i,
    input  logic [DW/8-1:0]   axi_wstrb_i,
    input  logic              axi_wvalid_i,
    output logic              axi_wready_o,
    output logic [1:0]        axi_bresp_o,
    output logic              axi_bvalid_o,
    input  logic              axi_bready_i,
    input  logic [AW-1:0]     axi_araddr_i,
    input  logic              axi_arvalid_i,
    output logic              axi_arready_o,
    output logic [DW-1:0]     axi_rdata_o,
    output logic [1:0]        axi_rresp_o,
    output logic              axi_rvalid_o,
    input  logic              axi_rready_i,
    output logic [AW-1:0]     sys_addr_o,
    output logic [DW-1:0]     sys_wdata_o,
    output logic              sys_wen_o,
    output logic              sys_ren_o,
    input  logic [DW-1:0]     sys_rdata_i,
    input  logic              sys_err_i,
    input  logic              sys_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW:0] TIMEOUT_L = (CW+1)'(TIMEOUT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wen_q, wen_d;
    logic            ren_q, ren_d;
    logic            bvalid_q, bvalid_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            grant_wr_s;
    logic            grant_rd_s;
    logic            unused_wstrb_s;

    // sys_bus has no byte enables, so strobes are dropped and writes go full-word
    assign unused_wstrb_s = ^axi_wstrb_i;

    // Arbitration: on a conflict serve the type opposite to the last one (last_q=1 means write)
    always_comb begin
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (rstn_i && (state_q == ST_IDLE)) begin
            if (axi_awvalid_i && axi_wvalid_i && (!axi_arvalid_i || !last_q)) begin
                grant_wr_s = 1'b1;
            end else if (axi_arvalid_i) begin
                grant_rd_s = 1'b1;
            end else begin
                grant_wr_s = 1'b0;
            end
        end else begin
            grant_rd_s = 1'b0;
        end
    end

    // Next-state and datapath updates for the transaction FSM
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
        ren_d    = 1'b0;
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        bresp_d  = bresp_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_wr_s) begin
                    op_d    = 1'b1;
                    last_d  = 1'b1;
                    addr_d  = axi_awaddr_i;
                    wdata_d = axi_wdata_i;
                    wen_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (grant_rd_s) begin
                    op_d    = 1'b0;
                    last_d  = 1'b0;
                    addr_d  = axi_araddr_i;
                    ren_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (state_q == ST_REQ) begin
                    cnt_d = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (sys_ack_i) begin
                    state_d = ST_RESP;
                    if (op_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = sys_err_i ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = sys_err_i ? RESP_SLVERR : RESP_OKAY;
                        rdata_d  = sys_rdata_i;
                    end
                end else if ((state_q == ST_WAIT) &&
                             (({1'b0, cnt_q} + (CW+1)'(1)) >= TIMEOUT_L)) begin
                    // Counter stops here, so it never wraps
                    cnt_d   = cnt_q;
                    state_d = ST_RESP;
                    if (op_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_DECERR;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_DECERR;
                        rdata_d  = {DW{1'b0}};
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (op_q && axi_bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (!op_q && axi_rready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            op_q     <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            addr_q   <= {AW{1'b0}};
            wdata_q  <= {DW{1'b0}};
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rresp_q  <= 2'b00;
            rdata_q  <= {DW{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign axi_awready_o = grant_wr_s;
    assign axi_wready_o  = grant_wr_s;
    assign axi_arready_o = grant_rd_s;
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rdata_o   = rdata_q;
    assign sys_addr_o    = addr_q;
    assign sys_wdata_o   = wdata_q;
    assign sys_wen_o     = wen_q;
    assign sys_ren_o     = ren_q;

endmodule
